fetch_unit: RTL

Instruction fetch and program-counter stage of the 16-bit multi-cycle CPU. It owns the PC, fetches 16-bit instruction words from instruction memory over a req/ready handshake, and holds each word for the decode/execute stages; op field [15:12] drives the control unit's `op` input. On each retire it applies the control unit's 2-bit PC source (PC+2, PC+imm, rs1+imm) to form the next PC and supplies the link value for jal/jalr.

---
 rtl/fetch_unit.sv | 83 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage of the 16-bit multi-cycle CPU.
// Owns the PC and IR, fetches over req/ready, retires via pc_src.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  input  logic [1:0]  pc_src,
  input  logic [15:0] imm,
  input  logic [15:0] rs1_val,
  input  logic        exec_done,
  output logic [15:0] instr_out,
  output logic [3:0]  op_out,
  output logic        instr_valid,
  output logic [15:0] pc_out,
  output logic [15:0] link_out,
  output logic [15:0] retire_cnt,
  output logic        halt
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      state;
  logic [15:0] nxt_pc;

  always_comb begin
    nxt_pc = pc_out + 16'd2;
    unique case (pc_src)
      2'b01:   nxt_pc = pc_out + imm;
      2'b10:   nxt_pc = rs1_val + imm;
      default: nxt_pc = pc_out + 16'd2;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc_out     <= RESET_PC;
      instr_out  <= 16'h0000;
      retire_cnt <= 16'h0000;
      halt       <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_ready) begin
            instr_out <= imem_rdata;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            retire_cnt <= retire_cnt + 16'd1;
            // odd target: fault without committing the PC
            if (nxt_pc[0]) begin
              halt  <= 1'b1;
              state <= S_HALT;
            end else begin
              pc_out <= nxt_pc;
              state  <= S_FETCH;
            end
          end
        end
        S_HALT: ;
        default: state <= S_HALT;
      endcase
    end
  end

  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc_out;
  assign instr_valid = (state == S_EXEC);
  assign op_out      = instr_out[15:12];
  assign link_out    = pc_out + 16'd2;

endmodule
